rf_wport_sched: RTL

Write-port scheduler and scoreboard for the register file. It shares the single register-file write port between the main pipeline's WB stage and a long-latency unit (divider or multi-cycle load) whose results come back out of order with the pipeline. It buffers up to two long-latency results and tracks their destination registers in a 32-bit scoreboard. It raises a stall to ID when a read hits a pending register, and exports the buffer head on a 38-bit forwarding bus in the same format as the other stage-to-ID buses.

---
 rtl/rf_wport_sched_if.sv | 36 +++
 rtl/rf_wport_sched.sv | 114 +++++++++++
 2 files changed

// File: rtl/rf_wport_sched_if.sv
// Bus bundle between the pipeline/long-latency unit and the register-file write-port scheduler.
interface rf_wport_sched_if;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_hold;
  logic        lu_issue;
  logic [4:0]  lu_waddr;
  logic        issue_ready;
  logic        lu_done_valid;
  logic [4:0]  lu_done_waddr;
  logic [31:0] lu_done_wdata;
  logic        lu_done_ready;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        stall_req;
  logic [37:0] lu_to_id;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        waw_err;

  modport master (
    output wb_we, wb_waddr, wb_wdata, lu_issue, lu_waddr,
           lu_done_valid, lu_done_waddr, lu_done_wdata, raddr1, raddr2,
    input  wb_hold, issue_ready, lu_done_ready, stall_req, lu_to_id,
           rf_we, rf_waddr, rf_wdata, waw_err
  );

  modport slave (
    input  wb_we, wb_waddr, wb_wdata, lu_issue, lu_waddr,
           lu_done_valid, lu_done_waddr, lu_done_wdata, raddr1, raddr2,
    output wb_hold, issue_ready, lu_done_ready, stall_req, lu_to_id,
           rf_we, rf_waddr, rf_wdata, waw_err
  );
endinterface

// File: rtl/rf_wport_sched.sv
// Shares the register-file write port between WB and a long-latency unit,
// buffering two out-of-order results and tracking pending destinations.
module rf_wport_sched #(
  parameter int STARVE_LIMIT = 3
) (
  input logic clk,
  input logic rst,
  rf_wport_sched_if.slave bus
);
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifo_waddr [2];
  logic [31:0]   fifo_wdata [2];
  logic          rd_ptr;
  logic [1:0]    count;
  logic [1:0]    outstanding;
  logic [SW-1:0] starve;
  logic [31:0]   sb;
  logic [31:0]   sb_next;
  logic          waw_err_q;

  logic          head_valid;
  logic [4:0]    head_waddr;
  logic [31:0]   head_wdata;
  logic          wr_ptr;
  logic          wbr;
  logic          drain;
  logic          push;
  logic          issue_acc;
  logic          head_hit1;
  logic          head_hit2;
  logic          rd_stall1;
  logic          rd_stall2;

  assign head_valid = (count != 2'd0);
  assign head_waddr = fifo_waddr[rd_ptr];
  assign head_wdata = fifo_wdata[rd_ptr];
  assign wr_ptr     = rd_ptr ^ count[0];

  assign bus.wb_hold       = (starve == SW'(STARVE_LIMIT)) && head_valid;
  assign wbr               = bus.wb_we && !bus.wb_hold;
  assign drain             = !wbr && head_valid;
  assign bus.lu_done_ready = (count != 2'd2);
  assign push              = bus.lu_done_valid && bus.lu_done_ready;

  // The pre-edge scoreboard gates issue, so a same-cycle drain of the register still blocks it.
  assign bus.issue_ready = (outstanding < 2'd2) && !((bus.lu_waddr != 5'd0) && sb[bus.lu_waddr]);
  assign issue_acc       = bus.lu_issue && bus.issue_ready;

  // A read that matches the buffer head is forwarded through lu_to_id instead of stalling.
  assign head_hit1 = head_valid && (head_waddr == bus.raddr1);
  assign head_hit2 = head_valid && (head_waddr == bus.raddr2);
  assign rd_stall1 = (bus.raddr1 != 5'd0) && sb[bus.raddr1] && !head_hit1;
  assign rd_stall2 = (bus.raddr2 != 5'd0) && sb[bus.raddr2] && !head_hit2;
  assign bus.stall_req = rd_stall1 || rd_stall2 || (bus.lu_issue && !bus.issue_ready);

  // Buffer data is not reset, so the bus is masked while the FIFO is empty.
  assign bus.lu_to_id = head_valid ? {(head_waddr != 5'd0), head_waddr, head_wdata} : 38'd0;
  assign bus.waw_err  = waw_err_q;

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = 5'd0;
    bus.rf_wdata = 32'd0;
    if (wbr) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.wb_waddr;
      bus.rf_wdata = bus.wb_wdata;
    end else if (head_valid) begin
      bus.rf_we    = (head_waddr != 5'd0);
      bus.rf_waddr = head_waddr;
      bus.rf_wdata = head_wdata;
    end
  end

  always_comb begin
    sb_next = sb;
    if (drain)
      sb_next[head_waddr] = 1'b0;
    if (issue_acc && (bus.lu_waddr != 5'd0))
      sb_next[bus.lu_waddr] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      outstanding <= 2'd0;
      starve      <= '0;
      sb          <= 32'd0;
      waw_err_q   <= 1'b0;
    end else begin
      if (drain)
        rd_ptr <= ~rd_ptr;
      count       <= count + {1'b0, push} - {1'b0, drain};
      outstanding <= outstanding + {1'b0, issue_acc} - {1'b0, drain && (outstanding != 2'd0)};
      if (!head_valid || drain)
        starve <= '0;
      else if (wbr && (starve != SW'(STARVE_LIMIT)))
        starve <= starve + SW'(1);
      sb <= sb_next;
      if ((wbr && sb[bus.wb_waddr]) || (bus.lu_done_valid && (outstanding == 2'd0)))
        waw_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_waddr[wr_ptr] <= bus.lu_done_waddr;
      fifo_wdata[wr_ptr] <= bus.lu_done_wdata;
    end
  end
endmodule
